rs_dec_info_deframer: RTL and testbench
=======================================

Name: rs_dec_info_deframer

Overview:
- Sits directly downstream of rs_decoder_16_8 and consumes its corrected-symbol stream (symb_out_val, symb_out_cnt, symb_corrected).
- Keeps the 8 information symbols of each 16-symbol codeword and discards the 8 parity symbols.
- Buffers up to two frames in a ping-pong store.
- Re-emits each frame on a framed valid/ready stream with sop/eop, so sinks with backpressure can follow the decoder.

Parameters:
DATA_W, 8, symbol width in bits
N, 16, codeword length in symbols
K, 8, information symbols per codeword, forwarded to the output

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
symb_out_val  input  1  decoder symbol valid
symb_out_cnt  input  8  index of the current symbol within the codeword, 0..N-1
symb_corrected  input  DATA_W  corrected symbol
dout_val  output  1  output symbol valid
dout_sop  output  1  first information symbol of a frame
dout_eop  output  1  last (K-th) information symbol of a frame
dout  output  DATA_W  information symbol
dout_rdy  input  1  sink ready; a transfer occurs when dout_val && dout_rdy
frame_drop  output  1  one-cycle pulse: an incoming frame was discarded because both banks were full
seq_err  output  1  one-cycle pulse: symb_out_cnt broke sequence
frames_out  output  16  count of frames fully delivered; wraps at 0xFFFF

Behaviour:
- Reset: all outputs 0, both banks empty, wr_bank=0, rd_bank=0, write expect-index=0, read FSM in IDLE, frames_out=0. Reset mid-frame discards all buffered data.
- Storage: two banks of K x DATA_W, each with a registered full flag.
- Write side. Acts only on cycles with symb_out_val=1.
  - cnt==0: start a frame. If bank[wr_bank] is full (flag value before the edge), mark the frame dropped, pulse frame_drop, and ignore the symbols with cnt 1..N-1 of that frame. Otherwise write index 0.
  - 0<cnt<K with cnt==expect: write bank[wr_bank][cnt].
  - cnt==K-1 accepted (frame not dropped): set full[wr_bank] and toggle wr_bank on the same edge.
  - K<=cnt<N: parity, ignored. expect tracks it for the sequence check.
  - expect wraps to 0 after N-1.
- Sequence error. Raised when cnt != expect while a frame is in progress (cnt != 0).
  - Pulse seq_err and abandon the partial frame; no bank is marked full.
  - Expect returns to 0. An out-of-sequence cnt==0 starts a new frame normally.
- Read FSM:
  - IDLE: if full[rd_bank], go to SEND with index=0.
  - SEND: drive dout=bank[rd_bank][index], dout_val=1, dout_sop=(index==0), dout_eop=(index==K-1).
  - On each dout_val && dout_rdy, increment index.
  - On the transfer with index==K-1: clear full[rd_bank], toggle rd_bank, increment frames_out. Go to SEND again if the other bank is full (no bubble); otherwise go to IDLE.
- Output registering and stability: all outputs are registered. While dout_val=1 and dout_rdy=0, dout, dout_sop and dout_eop hold stable. dout_val never drops mid-frame once asserted.
- Latency: the symbol with cnt=K-1 sampled at edge E gives dout_val=1 with sop after edge E+1, when the read side is idle. Full throughput is one symbol per clock when dout_rdy=1.
- Simultaneous events:
  - A bank freed and a cnt==0 targeting that bank on the same edge: the frame is dropped (the pre-edge full flag governs).
  - Write to one bank while reading the other is always allowed.
- Frame order is preserved; no reordering.

Test Plan:
- Single frame: codeword symbols 0..7 followed by parity 0xA0..0xA7, dout_rdy=1.
  -> dout 0..7 on consecutive cycles, sop with 0, eop with 7, no parity output, frames_out=1.
- Backpressure: same frame, dout_rdy toggled 1,0,0,1,...
  -> dout and sop/eop held while rdy=0, dout_val continuous, all 8 symbols delivered in order.
- Overflow: three back-to-back codewords (info 0..7, 8..15, 16..23) with dout_rdy=0, then dout_rdy=1.
  -> frame_drop pulses exactly once, at cnt==0 of frame 3.
  -> output is 0..15 as two frames with no bubble between them; frames_out=2.
- Sequence error: cnt 0,1,2,5.
  -> seq_err pulses on the cnt=5 cycle, no output.
  -> a following clean codeword with info 0x10..0x17 outputs 0x10..0x17.
- Reset mid-delivery: rst_n asserted at output index 3.
  -> all outputs 0 immediately.
  -> after release, a new frame with info 0..7 outputs correctly with frames_out=1.

Source files
------------

// File: rtl/rs_dec_info_deframer.sv
// Strips parity from the rs_decoder_16_8 corrected-symbol stream and replays the
// information symbols of each codeword as a sop/eop framed valid/ready stream.
module rs_dec_info_deframer #(
  parameter int DATA_W = 8,
  parameter int N      = 16,
  parameter int K      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              symb_out_val,
  input  logic [7:0]        symb_out_cnt,
  input  logic [DATA_W-1:0] symb_corrected,
  output logic              dout_val,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [DATA_W-1:0] dout,
  input  logic              dout_rdy,
  output logic              frame_drop,
  output logic              seq_err,
  output logic [15:0]       frames_out,
  output logic              dbg_rd_state
);

  // Output handshake: a symbol moves on every cycle where dout_val && dout_rdy;
  // once dout_val rises it stays high until eop transfers, and dout/sop/eop hold
  // while dout_rdy is low.

  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [7:0]    CNT_LAST  = 8'(N - 1);
  localparam logic [7:0]    INFO_LAST = 8'(K - 1);
  localparam logic [7:0]    INFO_N    = 8'(K);
  localparam logic [IW-1:0] IDX_LAST  = IW'(K - 1);

  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  logic [DATA_W-1:0] mem [2][K];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, rd_bank_q, rd_bank_d, other_bank;
  logic [7:0]        expect_q, expect_d;
  logic              accepting_q, accepting_d;
  logic              wr_en, set_full, clr_full, frm_inc;
  logic              drop_d, seq_err_d;
  logic [IW-1:0]     wr_idx;

  rd_state_t         rd_state_q, rd_state_d;
  logic [IW-1:0]     idx_q, idx_d, idx_inc;
  logic              val_d, sop_d, eop_d;
  logic [DATA_W-1:0] dout_d;

  assign wr_idx       = symb_out_cnt[IW-1:0];
  assign other_bank   = ~rd_bank_q;
  assign idx_inc      = idx_q + 1'b1;
  assign dbg_rd_state = (rd_state_q == RD_SEND);

  // Write side: sequence tracking, drop decision on the pre-edge full flag.
  always_comb begin
    wr_en       = 1'b0;
    set_full    = 1'b0;
    drop_d      = 1'b0;
    seq_err_d   = 1'b0;
    expect_d    = expect_q;
    accepting_d = accepting_q;
    if (symb_out_val) begin
      if (symb_out_cnt == 8'd0) begin
        expect_d = (CNT_LAST == 8'd0) ? 8'd0 : 8'd1;
        if (full_q[wr_bank_q]) begin
          drop_d      = 1'b1;
          accepting_d = 1'b0;
        end else begin
          wr_en       = 1'b1;
          accepting_d = 1'b1;
        end
      end else if (symb_out_cnt != expect_q) begin
        seq_err_d   = 1'b1;
        expect_d    = 8'd0;
        accepting_d = 1'b0;
      end else begin
        expect_d = (symb_out_cnt == CNT_LAST) ? 8'd0 : symb_out_cnt + 8'd1;
        if (accepting_q && (symb_out_cnt < INFO_N)) wr_en = 1'b1;
      end
      if (wr_en && (symb_out_cnt == INFO_LAST)) begin
        set_full    = 1'b1;
        accepting_d = 1'b0;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rd_bank_q] = 1'b0;
    if (set_full) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank_q][wr_idx] <= symb_corrected;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      expect_q    <= 8'd0;
      accepting_q <= 1'b0;
      frame_drop  <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      full_q      <= full_d;
      expect_q    <= expect_d;
      accepting_q <= accepting_d;
      frame_drop  <= drop_d;
      seq_err     <= seq_err_d;
      if (set_full) wr_bank_q <= ~wr_bank_q;
    end
  end

  // Read FSM: computes the next registered output word directly.
  always_comb begin
    rd_state_d = rd_state_q;
    idx_d      = idx_q;
    rd_bank_d  = rd_bank_q;
    val_d      = dout_val;
    sop_d      = dout_sop;
    eop_d      = dout_eop;
    dout_d     = dout;
    clr_full   = 1'b0;
    frm_inc    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        val_d = 1'b0;
        sop_d = 1'b0;
        eop_d = 1'b0;
        if (full_q[rd_bank_q]) begin
          rd_state_d = RD_SEND;
          idx_d      = '0;
          val_d      = 1'b1;
          sop_d      = 1'b1;
          eop_d      = (IDX_LAST == '0);
          dout_d     = mem[rd_bank_q][0];
        end
      end
      RD_SEND: begin
        if (dout_rdy) begin
          if (idx_q == IDX_LAST) begin
            clr_full  = 1'b1;
            frm_inc   = 1'b1;
            rd_bank_d = other_bank;
            idx_d     = '0;
            if (full_q[other_bank]) begin
              sop_d  = 1'b1;
              eop_d  = (IDX_LAST == '0);
              dout_d = mem[other_bank][0];
            end else begin
              rd_state_d = RD_IDLE;
              val_d      = 1'b0;
              sop_d      = 1'b0;
              eop_d      = 1'b0;
            end
          end else begin
            idx_d  = idx_inc;
            sop_d  = 1'b0;
            eop_d  = (idx_inc == IDX_LAST);
            dout_d = mem[rd_bank_q][idx_inc];
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      idx_q      <= '0;
      rd_bank_q  <= 1'b0;
      dout_val   <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout       <= '0;
      frames_out <= 16'd0;
    end else begin
      rd_state_q <= rd_state_d;
      idx_q      <= idx_d;
      rd_bank_q  <= rd_bank_d;
      dout_val   <= val_d;
      dout_sop   <= sop_d;
      dout_eop   <= eop_d;
      dout       <= dout_d;
      if (frm_inc) frames_out <= frames_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_rs_dec_info_deframer.sv
// Bench for rs_dec_info_deframer: frame-level reference model, per-cycle compare,
// and directed scenarios with literal expectations.
module tb_rs_dec_info_deframer;
  localparam int DATA_W = 8;
  localparam int N = 16;
  localparam int K = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              symb_out_val = 1'b0;
  logic [7:0]        symb_out_cnt = 8'd0;
  logic [DATA_W-1:0] symb_corrected = '0;
  logic              dout_rdy = 1'b0;
  logic              dout_val, dout_sop, dout_eop, frame_drop, seq_err, dbg_rd_state;
  logic [DATA_W-1:0] dout;
  logic [15:0]       frames_out;

  rs_dec_info_deframer #(.DATA_W(DATA_W), .N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .symb_out_val(symb_out_val), .symb_out_cnt(symb_out_cnt), .symb_corrected(symb_corrected),
    .dout_val(dout_val), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout(dout),
    .dout_rdy(dout_rdy), .frame_drop(frame_drop), .seq_err(seq_err),
    .frames_out(frames_out), .dbg_rd_state(dbg_rd_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frames of information symbols queued in arrival order,
  // occupancy counted in whole frames (store holds at most two).
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] part [K];
  int                m_expect, m_occ, m_pos;
  bit                m_acc, exp_drop, exp_seq, exp_val, hs_seen;
  logic [15:0]       m_frames;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_expect = 0; m_occ = 0; m_pos = 0; m_acc = 0;
      exp_drop = 0; exp_seq = 0; exp_val = 0; m_frames = 16'd0;
    end else begin
      int  pushed;
      int  cnt;
      bit  last_xfer;
      bit  done;
      pushed = 0; last_xfer = 0; done = 0;
      exp_drop = 0; exp_seq = 0;
      if (hs_seen) begin
        void'(exp_q.pop_front());
        last_xfer = (m_pos == K - 1);
        m_pos = (m_pos + 1) % K;
      end
      if (symb_out_val) begin
        cnt = int'(symb_out_cnt);
        if (cnt == 0) begin
          m_expect = 1;
          if (m_occ == 2) begin
            exp_drop = 1; m_acc = 0;
          end else begin
            part[0] = symb_corrected; m_acc = 1;
          end
        end else if (cnt != m_expect) begin
          exp_seq = 1; m_expect = 0; m_acc = 0;
        end else begin
          m_expect = (cnt == N - 1) ? 0 : cnt + 1;
          if (m_acc && cnt < K) begin
            part[cnt] = symb_corrected;
            if (cnt == K - 1) done = 1;
          end
        end
      end
      if (done) begin
        for (int i = 0; i < K; i++) exp_q.push_back(part[i]);
        pushed = K; m_acc = 0; m_occ++;
      end
      if (last_xfer) begin
        m_occ--; m_frames = m_frames + 16'd1;
      end
      exp_val = (exp_q.size() - pushed) > 0;
    end
  end

  // Scoreboard compare on the falling edge; logs every transfer.
  logic [DATA_W-1:0] got_q[$];
  int                got_cyc[$];
  int                cyc = 0;
  int                drop_cnt = 0;
  int                seq_cnt = 0;
  bit                stall_prev = 0;
  logic [DATA_W-1:0] prev_dout;
  logic [1:0]        prev_se;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      hs_seen = 0; stall_prev = 0;
    end else begin
      check("frame_drop", frame_drop, exp_drop);
      check("seq_err", seq_err, exp_seq);
      check("frames_out", frames_out, m_frames);
      check("dout_val", dout_val, exp_val);
      if (frame_drop) drop_cnt++;
      if (seq_err) seq_cnt++;
      if (stall_prev) begin
        check("hold_val", dout_val, 1'b1);
        check("hold_dout", dout, prev_dout);
        check("hold_sop_eop", {dout_sop, dout_eop}, prev_se);
      end
      if (dout_val && exp_q.size() > 0) begin
        check("dout", dout, exp_q[0]);
        check("dout_sop", dout_sop, (m_pos == 0));
        check("dout_eop", dout_eop, (m_pos == K - 1));
      end
      hs_seen = dout_val && dout_rdy;
      if (hs_seen) begin
        got_q.push_back(dout);
        got_cyc.push_back(cyc);
      end
      stall_prev = dout_val && !dout_rdy;
      prev_dout = dout;
      prev_se = {dout_sop, dout_eop};
    end
  end

  // driver tasks
  task automatic send_sym(input int cnt, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    symb_out_val = 1'b1;
    symb_out_cnt = 8'(cnt);
    symb_corrected = d;
  endtask

  task automatic val_off();
    @(posedge clk); #1;
    symb_out_val = 1'b0;
  endtask

  task automatic send_codeword(input logic [DATA_W-1:0] base);
    for (int i = 0; i < N; i++)
      send_sym(i, (i < K) ? base + DATA_W'(i) : 8'hA0 + DATA_W'(i - K));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; symb_out_val = 1'b0; dout_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) break;
      @(posedge clk);
    end
    check(name, got_q.size(), n);
  endtask

  task automatic check_run(input int base, input logic [DATA_W-1:0] first, input int len, input string name);
    for (int i = 0; i < len; i++)
      check(name, got_q[base + i], first + DATA_W'(i));
  endtask

  initial begin
    int base, d0, s0;

    #12;
    check("rst_dout_val", dout_val, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_sop_eop", {dout_sop, dout_eop}, 2'b00);
    check("rst_pulses", {frame_drop, seq_err}, 2'b00);
    check("rst_frames_out", frames_out, 16'd0);
    #5 rst_n = 1'b1;

    // single frame, sink always ready
    dout_rdy = 1'b1;
    base = got_q.size();
    send_codeword(8'h00);
    val_off();
    wait_got(base + 8, 40, "single_count");
    wait_cycles(4);
    check("single_no_parity", got_q.size(), base + 8);
    check_run(base, 8'h00, 8, "single_data");
    check("single_back_to_back", got_cyc[base + 7] - got_cyc[base], 7);
    check("single_frames_out", frames_out, 16'd1);

    // backpressure 1,0,0 repeating
    do_reset();
    base = got_q.size();
    send_codeword(8'h00);
    val_off();
    for (int i = 0; i < 60; i++) begin
      if (got_q.size() >= base + 8) break;
      dout_rdy = (i % 3 == 0);
      @(posedge clk); #1;
    end
    dout_rdy = 1'b1;
    wait_got(base + 8, 10, "bp_count");
    check_run(base, 8'h00, 8, "bp_data");
    check("bp_spacing", got_cyc[base + 7] - got_cyc[base], 21);
    wait_cycles(2);
    check("bp_frames_out", frames_out, 16'd1);

    // overflow: three codewords into a stalled sink
    do_reset();
    base = got_q.size();
    d0 = drop_cnt;
    send_codeword(8'h00);
    send_codeword(8'h08);
    send_codeword(8'h10);
    val_off();
    wait_cycles(2);
    check("ovf_drop_pulses", drop_cnt - d0, 1);
    check("ovf_nothing_yet", got_q.size(), base);
    dout_rdy = 1'b1;
    wait_got(base + 16, 40, "ovf_count");
    wait_cycles(6);
    check("ovf_third_dropped", got_q.size(), base + 16);
    check_run(base, 8'h00, 16, "ovf_data");
    check("ovf_no_bubble", got_cyc[base + 15] - got_cyc[base], 15);
    check("ovf_frames_out", frames_out, 16'd2);

    // sequence error 0,1,2,5 then a clean codeword
    do_reset();
    dout_rdy = 1'b1;
    base = got_q.size();
    s0 = seq_cnt;
    send_sym(0, 8'h00);
    send_sym(1, 8'h01);
    send_sym(2, 8'h02);
    send_sym(5, 8'h05);
    val_off();
    wait_cycles(6);
    check("seq_pulses", seq_cnt - s0, 1);
    check("seq_no_output", got_q.size(), base);
    send_codeword(8'h10);
    val_off();
    wait_got(base + 8, 40, "seq_recover_count");
    check_run(base, 8'h10, 8, "seq_recover_data");
    wait_cycles(2);
    check("seq_frames_out", frames_out, 16'd1);

    // reset while the fourth symbol is on the output
    do_reset();
    base = got_q.size();
    send_codeword(8'h00);
    val_off();
    dout_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (got_q.size() >= base + 3) break;
    end
    check("mid_reached_idx3", got_q.size(), base + 3);
    check("mid_idx3_value", dout, 8'h03);
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", dout_val, 1'b0);
    check("mid_rst_dout", dout, '0);
    check("mid_rst_sop_eop", {dout_sop, dout_eop}, 2'b00);
    check("mid_rst_frames_out", frames_out, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(4);
    check("mid_no_stale_output", got_q.size(), base + 3);
    base = got_q.size();
    send_codeword(8'h00);
    val_off();
    wait_got(base + 8, 40, "mid_new_count");
    check_run(base, 8'h00, 8, "mid_new_data");
    wait_cycles(2);
    check("mid_frames_out", frames_out, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
